load_store_unit: RTL and testbench

- Memory stage that sits directly downstream of the ALU in the RV32I core.
- Consumes the ALU result as an effective address and drives a valid/grant data-memory port.
- Handles byte-lane steering for SB/SH/SW and lane extraction with sign or zero extension for LB/LH/LW/LBU/LHU.
- Stalls the single-cycle core until the access completes, then presents load data for writeback.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: store lane steering, load extraction/extension and
// the illegal/misaligned access flag.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = rword >> {offset, 3'b000};

  always_comb begin
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    case (funct3)
      F3_B: begin
        wstrb      = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H: begin
        wstrb      = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
      F3_W:    rdata_ext = shifted;
      default: rdata_ext = '0;
    endcase
  end

  always_comb begin
    illegal = 1'b0;
    if (is_load && is_store)
      illegal = 1'b1;
    if (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      illegal = 1'b1;
    if (is_store && !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W))
      illegal = 1'b1;
    if ((funct3 == F3_H || funct3 == F3_HU) && offset[0])
      illegal = 1'b1;
    if (funct3 == F3_W && offset != 2'b00)
      illegal = 1'b1;
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: valid/grant data port, byte-lane handling, core stall.
// Optional macro LSU_TIMEOUT_EN aborts accesses stuck in REQ/WAIT for TIMEOUT cycles.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Handshake: the core holds req_valid until resp_valid; the request is
  // taken in IDLE and the core retires at the clock edge that ends DONE.

  lsu_state_t  state;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        idle;
  logic        accept;
  logic        al_load;
  logic        al_store;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_illegal;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt;
  logic             expired;
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`endif

  assign idle      = (state == IDLE);
  assign accept    = idle && req_valid && (is_load || is_store);
  assign req_ready = idle;
  assign stall     = accept || (state == REQ) || (state == WAIT);

  // Decode live inputs at accept time, latched fields afterwards for extraction.
  assign al_load  = idle ? is_load  : ld_q;
  assign al_store = idle ? is_store : !ld_q;
  assign al_f3    = idle ? funct3   : f3_q;
  assign al_off   = idle ? addr[1:0] : off_q;

  lsu_align u_align (
    .is_load    (al_load),
    .is_store   (al_store),
    .funct3     (al_f3),
    .offset     (al_off),
    .wdata      (wdata),
    .rword      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      ld_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ld_q  <= is_load;
            f3_q  <= funct3;
            off_q <= addr[1:0];
            if (al_illegal) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              err        <= 1'b1;
              rdata      <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wstrb <= is_store ? al_wstrb : 4'b0000;
              mem_wdata <= is_store ? al_wdata : 32'h0;
`ifdef LSU_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (ld_q) begin
              state <= WAIT;
            end else begin
              state      <= DONE;
              resp_valid <= 1'b1;
              err        <= 1'b0;
              rdata      <= '0;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (expired) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            state      <= DONE;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            rdata      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (mem_gnt) cnt <= cnt + 1'b1;
`endif
        end
        WAIT: begin
          if (mem_rvalid) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            err        <= 1'b0;
            rdata      <= al_rdata;
          end
`ifdef LSU_TIMEOUT_EN
          else if (expired) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            err        <= 1'b1;
            rdata      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          err        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: spec-level model, response queue and a
// per-cycle compare process, plus literal checks on key vectors.
`timescale 1ns/100ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_ready, stall, resp_valid, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  // model-driven expectations, consumed by the compare process
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_ready, exp_mreq, exp_resp, exp_we;
  logic [31:0] exp_maddr, exp_mwdata;
  logic [3:0]  exp_strb;
  logic [32:0] exp_q[$];
  logic [32:0] resp_e;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_strb;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
    .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // ---- specification-level model ----
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_illegal(input logic ld, st, input logic [2:0] f3, input logic [31:0] a);
    if (ld && st) return 1'b1;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (st && f3 > 3'd2) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] k);
    int m;
    m = ((1 << acc_size(f3)) - 1) << k;
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (acc_size(f3))
      1:       return {24'h0, wd[7:0]} * 32'h01010101;
      2:       return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] k, input logic [31:0] word);
    longint v, span;
    int bits;
    bits = 8 * acc_size(f3);
    if (bits == 32) return word;
    span = longint'(1) << bits;
    v = (longint'(word) >> (8 * k)) % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---- compare process ----
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {31'h0, stall}, {31'h0, exp_stall});
      check("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
      check("mem_req", {31'h0, mem_req}, {31'h0, exp_mreq});
      check("resp_valid", {31'h0, resp_valid}, {31'h0, exp_resp});
      if (exp_mreq) begin
        check("mem_addr", mem_addr, exp_maddr);
        check("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
        if (exp_we) begin
          check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, exp_strb});
          check("mem_wdata", mem_wdata, exp_mwdata);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 32'h1, 32'h0);
        end else begin
          resp_e = exp_q.pop_front();
          check("err", {31'h0, err}, {31'h0, resp_e[32]});
          check("rdata", rdata, resp_e[31:0]);
        end
      end
    end
  end

  task automatic set_exp(input logic s, r, m, v);
    exp_stall = s; exp_ready = r; exp_mreq = m; exp_resp = v;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_access(input logic ld, st, input logic [2:0] f3,
                           input logic [31:0] a, wd,
                           input int gnt_dly, rv_dly, input logic [31:0] word);
    bit ill;
    ill = model_illegal(ld, st, f3, a);
    exp_we = st; exp_maddr = {a[31:2], 2'b00};
    exp_strb = model_strb(f3, a[1:0]); exp_mwdata = model_wdata(f3, wd);
    if (ill) exp_q.push_back({1'b1, 32'h0});
    else if (ld) exp_q.push_back({1'b0, model_load(f3, a[1:0], word)});
    else exp_q.push_back(33'h0);
    req_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    if (!ill) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        mem_gnt = (i == gnt_dly);
        set_exp(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        if (i == 0) begin
          snap_addr = mem_addr; snap_wdata = mem_wdata; snap_strb = mem_wstrb;
        end
        next_cycle();
      end
      mem_gnt = 1'b0;
      if (ld) begin
        for (int i = 1; i <= rv_dly; i++) begin
          mem_rvalid = (i == rv_dly);
          mem_rdata  = (i == rv_dly) ? word : $urandom;
          set_exp(1'b1, 1'b0, 1'b0, 1'b0);
          next_cycle();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
    set_exp(1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'b0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    exp_we = 1'b0; exp_maddr = '0; exp_strb = '0; exp_mwdata = '0;
    #2;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_wstrb_wdata", {28'h0, mem_wstrb} | mem_wdata, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    next_cycle(); next_cycle();
    rst = 1'b0;
    chk_en = 1'b1;
    next_cycle();

    // SW
    do_access(1'b1 ^ 1'b1, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    check("sw_addr", snap_addr, 32'h00000100);
    check("sw_strb", {28'h0, snap_strb}, 32'hF);
    check("sw_wdata", snap_wdata, 32'hDEADBEEF);
    // SB top lane
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 1, 0, 32'h0);
    check("sb_addr", snap_addr, 32'h00000100);
    check("sb_strb", {28'h0, snap_strb}, 32'h8);
    check("sb_wdata", snap_wdata, 32'hA5A5A5A5);
    // SH upper half
    do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0);
    check("sh_strb", {28'h0, snap_strb}, 32'hC);
    check("sh_wdata", snap_wdata, 32'hABCDABCD);
    // loads from 0x12F45678
    do_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 1, 32'h12F45678);
    check("lb_rdata", rdata, 32'hFFFFFFF4);
    do_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 1, 32'h12F45678);
    check("lbu_rdata", rdata, 32'h000000F4);
    do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 1, 32'h12F45678);
    check("lhu_rdata", rdata, 32'h000012F4);
    do_access(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 0, 1, 32'h00008001);
    check("lh_rdata", rdata, 32'hFFFF8001);
    // illegal accesses
    do_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 0, 0, 32'h0);
    check("lh_mis_rdata", rdata, 32'h0);
    do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 0, 0, 32'h0);
    // LW with delayed grant and response
    do_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 3, 2, 32'hCAFEF00D);
    check("lw_rdata", rdata, 32'hCAFEF00D);
    check("lw_addr", snap_addr, 32'h00000020);

    // reset during WAIT
    chk_en = 1'b0;
    req_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
    next_cycle();
    mem_gnt = 1'b1;
    next_cycle();
    mem_gnt = 1'b0;
    check("wait_stall", {31'h0, stall}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_req", {31'h0, mem_req}, 32'h0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_req_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b0; is_load = 1'b0;
    #1;
    check("arst_stall", {31'h0, stall}, 32'h0);
    next_cycle();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle(); next_cycle();

`ifdef LSU_TIMEOUT_EN
    // grant never arrives: abort after 4 REQ cycles
    exp_we = 1'b0; exp_maddr = 32'h80;
    exp_q.push_back({1'b1, 32'h0});
    req_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h80;
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      set_exp(1'b1, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
    set_exp(1'b0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    req_valid = 1'b0; is_load = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    next_cycle();
`endif

    chk_en = 1'b0;
    check("exp_q_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
